uart_rx_frame_parser: RTL and testbench

Byte-level frame parser sitting directly downstream of the UART receive datapath. It consumes the received byte stream (SOF, LEN, payload, XOR checksum), buffers one payload, and checks the frame. It then presents the checked payload on a valid/ready byte stream to the command layer, with per-frame status pulses. The input side has no backpressure; the parser never stalls the receiver.

---
 rtl/uart_rx_parser_pkg.sv | 26 ++
 rtl/uart_rx_frame_buf.sv | 24 ++
 rtl/uart_rx_frame_parser.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx_frame_parser.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_parser_pkg.sv
// Shared types and constants for the UART receive frame parser.
package uart_rx_parser_pkg;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_DRAIN   = 3'd4
    } parser_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_BAD_LEN = 2'b01,
        ERR_BAD_CHK = 2'b10,
        ERR_ABORT   = 2'b11
    } err_code_t;

    localparam logic [7:0] DEFAULT_SOF = 8'hA5;

    // Buffer address width; at least one bit so a 1-byte buffer still has an index.
    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/uart_rx_frame_buf.sv
// Payload store: one synchronous write port, one combinational read port.
// Storage is deliberately not reset; contents are only read after being written.
module uart_rx_frame_buf #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_ptr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_ptr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Frame parser: SOF, LEN, payload, XOR checksum -> checked payload on a valid/ready stream.
// Optional inter-byte idle timeout enabled by defining UART_RX_PARSER_TIMEOUT_EN.
module uart_rx_frame_parser
    import uart_rx_parser_pkg::*;
#(
    parameter int         MAX_PAYLOAD    = 16,
    parameter logic [7:0] SOF_BYTE       = DEFAULT_SOF,
    parameter int         TIMEOUT_CYCLES = 8680
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    input  logic          in_error,
    output logic [7:0]    out_data,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic          frame_ok,
    output logic          frame_err,
    output logic [1:0]    err_code,
    output logic          drop,
    output logic          busy,
    output parser_state_t debug_state
);

    localparam int         CW      = $clog2(MAX_PAYLOAD + 1);
    localparam int         AW      = ptr_width(MAX_PAYLOAD);
    localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

    parser_state_t state;
    logic [CW-1:0] len_q;
    logic [CW-1:0] remaining;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    chk_acc;
    logic          out_valid_q;
    logic          frame_ok_q;
    logic          frame_err_q;
    err_code_t     err_q;
    logic          drop_q;

    logic          timeout;
    logic          abort;
    logic          handshake;
    logic          at_last;
    logic          wr_en;
    logic [7:0]    rd_data;

    // Output handshake: a byte transfers in any cycle where out_valid & out_ready;
    // out_valid/out_data/out_last hold steady until that transfer happens.
    assign handshake = out_valid_q & out_ready;
    assign at_last   = (CW'(rd_ptr) == (len_q - CW'(1)));
    assign abort     = in_error | timeout;
    assign wr_en     = (state == ST_PAYLOAD) && in_valid && !abort;

    uart_rx_frame_buf #(.AW(AW)) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_ptr  (wr_ptr),
        .wr_data (in_data),
        .rd_ptr  (rd_ptr),
        .rd_data (rd_data)
    );

`ifdef UART_RX_PARSER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if ((state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHK)) begin
            idle_cnt <= in_valid ? '0 : idle_cnt + TW'(1);
        end else begin
            idle_cnt <= '0;
        end
    end

    assign timeout = (idle_cnt == TW'(TIMEOUT_CYCLES));
`else
    // Without the timeout a stalled frame waits indefinitely; this is constant false.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_HUNT;
            len_q       <= '0;
            remaining   <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            chk_acc     <= 8'h00;
            out_valid_q <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_q       <= ERR_NONE;
            drop_q      <= 1'b0;
        end else begin
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            drop_q      <= 1'b0;
            case (state)
                ST_HUNT: begin
                    if (in_valid && (in_data == SOF_BYTE)) begin
                        state <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (abort) begin
                        frame_err_q <= 1'b1;
                        err_q       <= ERR_ABORT;
                        state       <= ST_HUNT;
                    end else if (in_valid) begin
                        chk_acc <= in_data;
                        if ((in_data == 8'h00) || (in_data > MAX_LEN)) begin
                            frame_err_q <= 1'b1;
                            err_q       <= ERR_BAD_LEN;
                            state       <= ST_HUNT;
                        end else begin
                            len_q     <= in_data[CW-1:0];
                            remaining <= in_data[CW-1:0];
                            wr_ptr    <= '0;
                            state     <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (abort) begin
                        frame_err_q <= 1'b1;
                        err_q       <= ERR_ABORT;
                        state       <= ST_HUNT;
                    end else if (in_valid) begin
                        chk_acc   <= chk_acc ^ in_data;
                        wr_ptr    <= wr_ptr + AW'(1);
                        remaining <= remaining - CW'(1);
                        if (remaining == CW'(1)) begin
                            state <= ST_CHK;
                        end
                    end
                end
                ST_CHK: begin
                    if (abort) begin
                        frame_err_q <= 1'b1;
                        err_q       <= ERR_ABORT;
                        state       <= ST_HUNT;
                    end else if (in_valid) begin
                        if (in_data == chk_acc) begin
                            frame_ok_q  <= 1'b1;
                            err_q       <= ERR_NONE;
                            out_valid_q <= 1'b1;
                            rd_ptr      <= '0;
                            state       <= ST_DRAIN;
                        end else begin
                            frame_err_q <= 1'b1;
                            err_q       <= ERR_BAD_CHK;
                            state       <= ST_HUNT;
                        end
                    end
                end
                ST_DRAIN: begin
                    // No input backpressure exists, so bytes arriving now are lost.
                    drop_q <= in_valid;
                    if (handshake) begin
                        if (at_last) begin
                            out_valid_q <= 1'b0;
                            state       <= ST_HUNT;
                        end else begin
                            rd_ptr <= rd_ptr + AW'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_HUNT;
                end
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_valid_q ? rd_data : 8'h00;
    assign out_last    = out_valid_q & at_last;
    assign frame_ok    = frame_ok_q;
    assign frame_err   = frame_err_q;
    assign err_code    = err_q;
    assign drop        = drop_q;
    assign busy        = (state != ST_HUNT);
    assign debug_state = state;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Directed bench for uart_rx_frame_parser; define UART_RX_PARSER_TIMEOUT_EN for the timeout build.
module tb_uart_rx_frame_parser;
    import uart_rx_parser_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_error;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic          frame_ok;
    logic          frame_err;
    logic [1:0]    err_code;
    logic          drop;
    logic          busy;
    parser_state_t debug_state;

    int checks = 0;
    int errors = 0;
    int fired_at;
    logic seen_err;

    always #5 clk = ~clk;

    uart_rx_frame_parser dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_error    (in_error),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .frame_ok    (frame_ok),
        .frame_err   (frame_err),
        .err_code    (err_code),
        .drop        (drop),
        .busy        (busy),
        .debug_state (debug_state)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Byte is taken at the next rising edge; returns 1 time unit after it.
    task automatic send_byte(input logic [7:0] b, input logic err);
        in_data  = b;
        in_valid = 1'b1;
        in_error = err;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_error = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_error  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_frame_ok", frame_ok, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_err_code", err_code, 2'b00);
        check("rst_drop", drop, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        step();

        // Good 3-byte frame: chk = 03^11^22^33 = 03
        send_byte(8'hA5, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h03, 1'b0);
        check("t1_frame_ok", frame_ok, 1'b1);
        check("t1_valid0", out_valid, 1'b1);
        check("t1_data0", out_data, 8'h11);
        check("t1_last0", out_last, 1'b0);
        check("t1_busy", busy, 1'b1);
        step();
        check("t1_ok_pulse", frame_ok, 1'b0);
        check("t1_data1", out_data, 8'h22);
        check("t1_last1", out_last, 1'b0);
        step();
        check("t1_data2", out_data, 8'h33);
        check("t1_last2", out_last, 1'b1);
        step();
        check("t1_valid_end", out_valid, 1'b0);
        check("t1_data_end", out_data, 8'h00);
        check("t1_busy_end", busy, 1'b0);

        // Bad checksum
        send_byte(8'hA5, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h04, 1'b0);
        check("t2_frame_err", frame_err, 1'b1);
        check("t2_err_code", err_code, 2'b10);
        check("t2_valid", out_valid, 1'b0);
        check("t2_busy", busy, 1'b0);
        check("t2_ok", frame_ok, 1'b0);
        step();
        check("t2_err_pulse", frame_err, 1'b0);
        check("t2_code_held", err_code, 2'b10);

        // Bad lengths: zero and MAX_PAYLOAD+1
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        check("t3_len0_err", frame_err, 1'b1);
        check("t3_len0_code", err_code, 2'b01);
        check("t3_len0_busy", busy, 1'b0);
        step();
        check("t3_len0_pulse", frame_err, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h11, 1'b0);
        check("t3_len17_err", frame_err, 1'b1);
        check("t3_len17_code", err_code, 2'b01);
        check("t3_len17_busy", busy, 1'b0);
        // Following 1-byte frame: chk = 01^5A = 5B
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h5A, 1'b0);
        send_byte(8'h5B, 1'b0);
        check("t3_ok", frame_ok, 1'b1);
        check("t3_code_clr", err_code, 2'b00);
        check("t3_data", out_data, 8'h5A);
        check("t3_last", out_last, 1'b1);
        step();
        check("t3_valid_end", out_valid, 1'b0);

        // Backpressure and drop: chk = 02^C3^3C = FD
        out_ready = 1'b0;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'hC3, 1'b0);
        send_byte(8'h3C, 1'b0);
        send_byte(8'hFD, 1'b0);
        check("t4_ok", frame_ok, 1'b1);
        check("t4_data_a", out_data, 8'hC3);
        step();
        check("t4_data_b", out_data, 8'hC3);
        check("t4_last_b", out_last, 1'b0);
        step();
        check("t4_data_c", out_data, 8'hC3);
        send_byte(8'h7E, 1'b0);
        check("t4_drop", drop, 1'b1);
        check("t4_data_d", out_data, 8'hC3);
        check("t4_valid_d", out_valid, 1'b1);
        step();
        check("t4_drop_pulse", drop, 1'b0);
        check("t4_data_e", out_data, 8'hC3);
        out_ready = 1'b1;
        step();
        check("t4_data_f", out_data, 8'h3C);
        check("t4_last_f", out_last, 1'b1);
        step();
        check("t4_valid_end", out_valid, 1'b0);
        check("t4_busy_end", busy, 1'b0);

        // Line error aborts, then a good frame: chk = 02^10^20 = 32
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'hAA, 1'b1);
        check("t5_err", frame_err, 1'b1);
        check("t5_code", err_code, 2'b11);
        check("t5_busy", busy, 1'b0);
        check("t5_state", debug_state, ST_HUNT);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h32, 1'b0);
        check("t5_ok", frame_ok, 1'b1);
        check("t5_data0", out_data, 8'h10);
        step();
        check("t5_data1", out_data, 8'h20);
        check("t5_last1", out_last, 1'b1);
        step();
        check("t5_valid_end", out_valid, 1'b0);

        // Stalled frame
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h55, 1'b0);
`ifdef UART_RX_PARSER_TIMEOUT_EN
        fired_at = 0;
        for (int i = 1; i <= 9000; i++) begin
            step();
            if (frame_err) begin
                fired_at = i;
                break;
            end
        end
        check("t6_timeout_seen", (fired_at != 0), 1'b1);
        check("t6_timeout_window", (fired_at >= 8680 && fired_at <= 8682), 1'b1);
        check("t6_code", err_code, 2'b11);
        check("t6_busy", busy, 1'b0);
`else
        seen_err = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (frame_err) seen_err = 1'b1;
        end
        check("t6_no_err", seen_err, 1'b0);
        check("t6_busy_held", busy, 1'b1);
        check("t6_state", debug_state, ST_PAYLOAD);
`endif

        // Reset mid-frame clears everything without a pulse
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t7_busy", busy, 1'b0);
        check("t7_err", frame_err, 1'b0);
        check("t7_code", err_code, 2'b00);
        step();
        rst_n = 1'b1;
        step();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'h76, 1'b0);
        check("t7_ok", frame_ok, 1'b1);
        check("t7_data", out_data, 8'h77);
        step();
        check("t7_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
